// File: rtl/fme_stage_sequencer.sv
// Per-stage enable sequencer for the FME pipeline: each stage follows its upstream
// enable after a runtime fill/drain latency, with hysteresis against short pulses.
module fme_stage_sequencer #(
   parameter int unsigned NUM_STAGES = 2,
   parameter int unsigned LAT_WIDTH  = 4
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            enable,
   input  logic                            flush,
   input  logic [NUM_STAGES*LAT_WIDTH-1:0] stage_latency,
   output logic [NUM_STAGES-1:0]           stage_enable,
   output logic                            busy,
   output logic                            done,
   output logic [7:0]                      block_count
);
   localparam int unsigned CW = LAT_WIDTH + 1;

   logic [LAT_WIDTH-1:0]  cnt_q     [NUM_STAGES];
   logic [LAT_WIDTH-1:0]  cnt_d     [NUM_STAGES];
   logic [LAT_WIDTH-1:0]  lat_q     [NUM_STAGES];
   logic [LAT_WIDTH-1:0]  lat_d     [NUM_STAGES];
   logic [LAT_WIDTH-1:0]  lat_field [NUM_STAGES];
   logic [NUM_STAGES:0]   up_chain;
   logic [NUM_STAGES-1:0] en_d;
   logic [NUM_STAGES-1:0] clr;
   logic [NUM_STAGES-1:0] cnt_nz;

   // Stage k's upstream is stage k-1; stage 0 listens to the block enable.
   assign up_chain = {stage_enable, enable};

   // Saturating hysteresis counter, set/clear decision and shadow-latency reload per stage.
   always_comb begin
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
         lat_field[k] = stage_latency[k*LAT_WIDTH +: LAT_WIDTH];
         cnt_d[k]     = cnt_q[k];
         lat_d[k]     = lat_q[k];
         en_d[k]      = stage_enable[k];
         clr[k]       = 1'b0;
         cnt_nz[k]    = (cnt_q[k] != '0);
         if (up_chain[k]) begin
            if (cnt_q[k] < lat_q[k]) cnt_d[k] = cnt_q[k] + LAT_WIDTH'(1);
            if (({1'b0, cnt_q[k]} + CW'(1)) >= {1'b0, lat_q[k]}) en_d[k] = 1'b1;
         end else begin
            if (cnt_nz[k]) cnt_d[k] = cnt_q[k] - LAT_WIDTH'(1);
            if (cnt_q[k] <= LAT_WIDTH'(1)) begin
               en_d[k] = 1'b0;
               clr[k]  = stage_enable[k];
            end
            // Latency changes only take effect once the stage is fully idle.
            if (!cnt_nz[k] && !stage_enable[k]) lat_d[k] = lat_field[k];
         end
      end
   end

   assign busy = enable | (|stage_enable) | (|cnt_nz);

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         for (int k = 0; k < int'(NUM_STAGES); k++) begin
            cnt_q[k] <= '0;
            lat_q[k] <= lat_field[k];
         end
         stage_enable <= '0;
         done         <= 1'b0;
         if (reset) block_count <= '0;
      end else begin
         for (int k = 0; k < int'(NUM_STAGES); k++) begin
            cnt_q[k] <= cnt_d[k];
            lat_q[k] <= lat_d[k];
         end
         stage_enable <= en_d;
         // A block completes when the last stage drops through its normal clear.
         done <= clr[NUM_STAGES-1];
         if (clr[NUM_STAGES-1]) block_count <= block_count + 8'd1;
      end
   end

endmodule

// File: doc/fme_stage_sequencer.md
# fme_stage_sequencer

Parametrised enable sequencer for the fractional motion estimation top level. It takes the block-level `enable` and produces one enable per pipeline stage (interpolation, search, and further stages as they are added). Each stage's enable follows its upstream enable after a programmable fill/drain latency, with hysteresis that rejects short upstream pulses. It also reports block completion (`done`, `block_count`) and activity (`busy`). It generalises the fixed interpolation-to-search enable counter to N stages with runtime latencies.

## Interface
- `NUM_STAGES`, default 2: number of sequenced stages; minimum 1.
- `LAT_WIDTH`, default 4: width of each per-stage latency field and counter.
- `clock`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high; clears all state.
- `enable`  input  1: upstream enable (valid block data present at the interpolation inputs).
- `flush`  input  1: synchronous abort; clears enables and counters, keeps `block_count`.
- `stage_latency`  input  `NUM_STAGES*LAT_WIDTH`: field k (bits `[k*LAT_WIDTH +: LAT_WIDTH]`) is latency L_k of stage k.
- `stage_enable`  output  `NUM_STAGES`: bit k is the registered enable of stage k.
- `busy`  output  1: combinational; `enable` OR any `stage_enable` bit OR any counter nonzero.
- `done`  output  1: one-cycle pulse when the last stage's enable falls.
- `block_count`  output  8: number of completed blocks; wraps.

## Operation
- Upstream of stage 0 is `enable`. Upstream of stage k (k ≥ 1) is `stage_enable[k-1]`.
- Each stage k has a saturating up/down counter c_k in the range [0, Lk_act], where Lk_act is the shadow latency. Per cycle:
  - Upstream high: c_k ← min(c_k+1, Lk_act).
  - Upstream low: c_k ← max(c_k−1, 0).
- `stage_enable[k]` is set when upstream is high and (c_k+1) ≥ Lk_act. The comparison is evaluated at LAT_WIDTH+1 bits.
- `stage_enable[k]` is cleared when upstream is low and c_k ≤ 1.
- `stage_enable[k]` holds its value otherwise.
- Resulting edge delays for upstream pulses of length ≥ L_k:
  - Rising edge delayed by max(L_k,1) cycles.
  - Falling edge delayed by max(L_k,1) cycles.
  - L_k = 0 and L_k = 1 both give a pure 1-cycle delay.
- An upstream pulse shorter than L_k never asserts `stage_enable[k]`. The counter then decays back to 0.
- Shadow latency Lk_act loads from field k of `stage_latency` in these cases:
  - during `reset`;
  - during `flush`;
  - on any cycle where stage k is idle: c_k = 0, `stage_enable[k]` = 0, and upstream low.
- Changes to `stage_latency` while a stage is active are ignored until that stage next goes idle.
- `done` is registered. It is high in the cycle after the edge on which `stage_enable[NUM_STAGES-1]` is cleared by the normal clear rule, i.e. coincident with the first low cycle. `block_count` increments on that same edge, with modulo-256 wrap.
- Flush behaviour:
  - Effect: all c_k ← 0, all `stage_enable` ← 0, `done` ← 0; `block_count` held.
  - A flush-induced fall never produces `done` and never increments `block_count`.
  - Flush dominates `enable` in the same cycle.
- Reset behaviour:
  - Effect: everything a flush does, plus `block_count` ← 0. `reset` dominates `flush` and `enable`.
  - Reset values: `stage_enable` = 0, `done` = 0, `block_count` = 0, and all counters 0.
  - `busy` therefore equals `enable` during and right after reset.

## Timing
- Cycle numbering: `enable` rises at cycle 0 (first sampled edge).
- `stage_enable[0]` first reads high at cycle max(L_0,1).
- `stage_enable[k]` first reads high at the sum of max(L_j,1) for j = 0..k.
- Same accumulation applies to falling edges, measured from the first low cycle of `enable`.
- `done` is high on exactly one cycle per completed block. That is the first cycle `stage_enable[NUM_STAGES-1]` reads low.
- Back-to-back blocks behave as follows:
  - If `enable` drops for fewer than L_0 cycles, stage 0 stays high and no `done` is produced (merged block).
  - With L_0 ≤ 1, any low cycle ends the block.
- `enable` re-rising in the same cycle as the last-stage clear is a valid done cycle; the new block's fill proceeds independently.
- No combinational path from `enable` to `stage_enable` or `done`. `busy` is the only combinational output.

## Test plan
- NUM_STAGES=2, L={3,5}, `enable` high for cycles 0–19:
  - `stage_enable[0]` high cycles 3–22; `stage_enable[1]` high cycles 8–27.
  - `done` at cycle 28 only; `block_count`=1; `busy` low from cycle 28.
- L_0=3, `enable` high cycles 0–1 only:
  - `stage_enable` stays 0, no `done`, `block_count`=0.
  - `busy` high through cycle 3 while c_0 decays 2→0.
- All L=0, NUM_STAGES=3, single-cycle `enable` at cycle 0:
  - `stage_enable` bits pulse at cycles 1, 2, 3.
  - `done` at 4; `block_count`=1.
- Latency change while busy: L_0 changed 3→6 at cycle 5 of an active block.
  - Current block keeps 3-cycle drain.
  - Next block, after idle, fills in 6 cycles.
- Flush mid-block:
  - `flush` at cycle 10 of the first scenario: all enables 0 at cycle 11, no `done`, `block_count` unchanged.
  - Repeat with `reset` instead: `block_count` 0 and all counters 0.
- Run 256 complete blocks (L={1,1}, 4-cycle `enable`, 4-cycle gap): `block_count` wraps 255→0 on the 256th `done`, with no missed or double pulses.
